// File: rtl/mixer_pkg.sv
// Shared definitions for the time-shared mixer: sizing helpers and the pipeline entry layout.
package mixer_pkg;

    localparam int DEF_INPUT_WIDTH  = 14;
    localparam int DEF_OUTPUT_WIDTH = 14;
    localparam int DEF_TAG_WIDTH    = 2;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end
        end
        return width;
    endfunction

    // Scaling distance between the full product and the result: >0 shifts right, <0 shifts left.
    function automatic int scale_shift(input int input_width, input int output_width);
        return 2 * input_width - output_width;
    endfunction

    typedef struct packed {
        logic                                valid;
        logic [DEF_TAG_WIDTH-1:0]            tag;
        logic signed [2*DEF_INPUT_WIDTH-1:0] data;
    } mixer_entry_t;

endpackage

// File: rtl/mixer_tag_pipe.sv
// Two-stage signed multiply / truncate pipeline carrying a valid bit and a routing tag.
module mixer_tag_pipe
    import mixer_pkg::*;
#(
    parameter int INPUT_WIDTH  = 14,
    parameter int OUTPUT_WIDTH = 14,
    parameter int TAG_WIDTH    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           acc_valid,
    input  logic [TAG_WIDTH-1:0]           acc_tag,
    input  logic signed [INPUT_WIDTH-1:0]  op_a,
    input  logic signed [INPUT_WIDTH-1:0]  op_b,
    output logic                           mul_valid,
    output logic                           scl_valid,
    output logic [TAG_WIDTH-1:0]           scl_tag,
    output logic signed [OUTPUT_WIDTH-1:0] scl_data
);

    localparam int PROD_WIDTH = 2 * INPUT_WIDTH;
    localparam int SHIFT      = scale_shift(INPUT_WIDTH, OUTPUT_WIDTH);

    typedef struct packed {
        logic                         valid;
        logic [TAG_WIDTH-1:0]         tag;
        logic signed [PROD_WIDTH-1:0] data;
    } mul_entry_t;

    typedef struct packed {
        logic                           valid;
        logic [TAG_WIDTH-1:0]           tag;
        logic signed [OUTPUT_WIDTH-1:0] data;
    } scl_entry_t;

    mul_entry_t                     mul_q;
    scl_entry_t                     scl_q;
    logic signed [PROD_WIDTH-1:0]   op_a_ext;
    logic signed [PROD_WIDTH-1:0]   op_b_ext;
    logic signed [PROD_WIDTH-1:0]   product;
    logic signed [OUTPUT_WIDTH-1:0] scaled;

    assign op_a_ext = PROD_WIDTH'(op_a);
    assign op_b_ext = PROD_WIDTH'(op_b);
    assign product  = op_a_ext * op_b_ext;

    // Floor shift then wrap to the result width is just a bit slice of the product.
    generate
        if (SHIFT > 0) begin : g_shift_right
            logic unused_low_bits;
            assign scaled          = mul_q.data[PROD_WIDTH-1:SHIFT];
            assign unused_low_bits = ^mul_q.data[SHIFT-1:0];
        end else if (SHIFT < 0) begin : g_shift_left
            assign scaled = {mul_q.data, {(-SHIFT){1'b0}}};
        end else begin : g_pass
            assign scaled = mul_q.data;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_q <= '0;
            scl_q <= '0;
        end else begin
            mul_q.valid <= acc_valid;
            mul_q.tag   <= acc_tag;
            mul_q.data  <= product;
            scl_q.valid <= mul_q.valid;
            scl_q.tag   <= mul_q.tag;
            scl_q.data  <= scaled;
        end
    end

    assign mul_valid = mul_q.valid;
    assign scl_valid = scl_q.valid;
    assign scl_tag   = scl_q.tag;
    assign scl_data  = scl_q.data;

endmodule

// File: rtl/mixer_rr_scheduler.sv
// Round-robin share of one multiply/truncate pipeline across N_REQ channels; results are
// routed back to the granted channel by the tag carried down the pipeline.
module mixer_rr_scheduler
    import mixer_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int INPUT_WIDTH  = 14,
    parameter int OUTPUT_WIDTH = 14,
    parameter int TAG_WIDTH    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ*INPUT_WIDTH-1:0]    req_a,
    input  logic [N_REQ*INPUT_WIDTH-1:0]    req_b,
    output logic [N_REQ-1:0]                res_valid,
    output logic [N_REQ*OUTPUT_WIDTH-1:0]   res_data,
    output logic                            busy
);

    logic [TAG_WIDTH-1:0]           rr_ptr;
    logic [TAG_WIDTH-1:0]           rr_ptr_next;
    logic [TAG_WIDTH-1:0]           grant_tag;
    logic [N_REQ-1:0]               grant;
    logic                           grant_found;
    logic                           transfer;
    logic signed [INPUT_WIDTH-1:0]  sel_a;
    logic signed [INPUT_WIDTH-1:0]  sel_b;
    logic                           mul_valid;
    logic                           scl_valid;
    logic [TAG_WIDTH-1:0]           scl_tag;
    logic signed [OUTPUT_WIDTH-1:0] scl_data;

    function automatic int rr_index(input int base, input int offset);
        return (base + offset) % N_REQ;
    endfunction

    always_comb begin
        grant       = '0;
        grant_tag   = '0;
        grant_found = 1'b0;
        rr_ptr_next = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid[rr_index(int'(rr_ptr), k)]) begin
                grant_found                        = 1'b1;
                grant[rr_index(int'(rr_ptr), k)]   = 1'b1;
                grant_tag   = TAG_WIDTH'(rr_index(int'(rr_ptr), k));
                rr_ptr_next = TAG_WIDTH'(rr_index(int'(rr_ptr), k + 1));
            end
        end
    end

    // Grant is masked while reset is held so no channel sees a handshake it cannot complete.
    assign req_ready = rst ? '0 : grant;
    assign transfer  = grant_found && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= rr_ptr_next;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*INPUT_WIDTH +: INPUT_WIDTH];
                sel_b = req_b[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    mixer_tag_pipe #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .TAG_WIDTH    (TAG_WIDTH)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .acc_valid (transfer),
        .acc_tag   (grant_tag),
        .op_a      (sel_a),
        .op_b      (sel_b),
        .mul_valid (mul_valid),
        .scl_valid (scl_valid),
        .scl_tag   (scl_tag),
        .scl_data  (scl_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= '0;
            res_data  <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                res_valid[i] <= scl_valid && (scl_tag == TAG_WIDTH'(i));
                if (scl_valid && (scl_tag == TAG_WIDTH'(i))) begin
                    res_data[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= scl_data;
                end
            end
        end
    end

    assign busy = mul_valid | scl_valid | (|res_valid);

endmodule

// File: tb/tb_mixer_rr_scheduler.sv
// Scoreboard bench for the round-robin mixer scheduler: grants, results, latency and busy.
module tb_mixer_rr_scheduler;

    localparam int N_REQ = 4;
    localparam int IW    = 14;
    localparam int OW    = 14;
    localparam int TW    = 2;
    localparam int SHIFT = 2 * IW - OW;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*IW-1:0]   req_a = '0;
    logic [N_REQ*IW-1:0]   req_b = '0;
    logic [N_REQ-1:0]      res_valid;
    logic [N_REQ*OW-1:0]   res_data;
    logic                  busy;

    mixer_rr_scheduler #(
        .N_REQ        (N_REQ),
        .INPUT_WIDTH  (IW),
        .OUTPUT_WIDTH (OW),
        .TAG_WIDTH    (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     tag;
        longint data;
        int     cycle;
    } exp_t;

    exp_t   sb_q[$];
    longint cap_q[$];
    longint model_data[N_REQ];
    int     model_ptr = 0;
    int     cycle = 0;
    int     n_checks = 0;
    int     n_pass = 0;
    int     last_grant = -1;
    logic   last_busy = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    endtask

    function automatic longint model_mix(input longint a, input longint b);
        longint p, r, mask;
        p    = a * b;
        r    = p >>> SHIFT;
        mask = (longint'(1) << OW) - 1;
        r    = r & mask;
        if (r >= (longint'(1) << (OW - 1))) r = r - (longint'(1) << OW);
        return r;
    endfunction

    function automatic int model_grant(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic longint op_of(input logic [N_REQ*IW-1:0] bus, input int i);
        logic [IW-1:0] s;
        s = bus[i*IW +: IW];
        return longint'($signed(s));
    endfunction

    function automatic longint res_slice(input int i);
        logic [OW-1:0] s;
        s = res_data[i*OW +: OW];
        return longint'($signed(s));
    endfunction

    function automatic logic [N_REQ*OW-1:0] model_vec();
        logic [N_REQ*OW-1:0] v;
        v = '0;
        for (int i = 0; i < N_REQ; i++) v[i*OW +: OW] = OW'(model_data[i]);
        return v;
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*IW +: IW] = IW'(a);
        req_b[i*IW +: IW] = IW'(b);
    endtask

    // One clock: check the grant for the current inputs, then check what comes out.
    task automatic tick();
        int                g;
        logic [N_REQ-1:0]  want;
        logic              busy_exp;
        exp_t              e;
        #1;
        g    = rst ? -1 : model_grant(req_valid, model_ptr);
        want = '0;
        if (g >= 0) want[g] = 1'b1;
        check("req_ready", req_ready, want);
        if (g >= 0) begin
            e.tag   = g;
            e.data  = model_mix(op_of(req_a, g), op_of(req_b, g));
            e.cycle = cycle;
            sb_q.push_back(e);
            model_ptr = (g + 1) % N_REQ;
        end
        last_grant = g;
        @(posedge clk);
        cycle++;
        @(negedge clk);
        busy_exp = 1'b0;
        foreach (sb_q[i]) begin
            if (cycle - sb_q[i].cycle >= 1 && cycle - sb_q[i].cycle <= 3) busy_exp = 1'b1;
        end
        last_busy = busy;
        check("busy", busy, busy_exp);
        if (res_valid != '0) begin
            if (sb_q.size() == 0) begin
                check("spurious_res_valid", res_valid, 0);
            end else begin
                e = sb_q.pop_front();
                check("res_valid", res_valid, 64'(1) << e.tag);
                check("res_latency", cycle - e.cycle, 3);
                model_data[e.tag] = e.data;
                check("res_data", res_slice(e.tag), e.data);
                if (e.tag == 2) cap_q.push_back(res_slice(2));
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        while (sb_q.size() > 0 && n < 12) begin
            tick();
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
        check("res_data_hold", res_data, model_vec());
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        sb_q.delete();
        model_ptr = 0;
        for (int i = 0; i < N_REQ; i++) model_data[i] = 0;
        for (int i = 0; i < n; i++) tick();
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;
    endtask

    longint ext_a[4] = '{-8192, -8192, 0, -1};
    longint ext_b[4] = '{8191, -8192, 1234, 1};
    longint ext_r[4] = '{-4096, 4096, 0, -1};
    longint ramp_r[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    initial begin
        int busy_cnt;
        int wait_cnt;
        int max_wait;

        // Reset with every requester asserting: no grant may leak out.
        req_valid = '1;
        apply_reset(2);
        req_valid = '0;

        // Single request from channel 0.
        set_op(0, 1000, 2000);
        req_valid = 4'b0001;
        busy_cnt  = 0;
        tick();
        busy_cnt += int'(last_busy);
        req_valid = '0;
        while (sb_q.size() > 0 && busy_cnt < 10) begin
            tick();
            busy_cnt += int'(last_busy);
        end
        check("t1_res0", res_slice(0), 122);
        check("t1_busy_cycles", busy_cnt, 3);
        tick();
        check("t1_busy_idle", busy, 0);

        // All channels contending continuously.
        for (int i = 0; i < N_REQ; i++) set_op(i, i + 1, 8191 - i * 1000);
        req_valid = '1;
        for (int n = 0; n < 12; n++) tick();
        drain();

        // Channel 1 held, the others toggling at random.
        wait_cnt  = 0;
        max_wait  = 0;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                set_op(i, int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192);
            end
            req_valid = {1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'($urandom_range(1))};
            tick();
            if (last_grant == 1) begin
                if (wait_cnt > max_wait) max_wait = wait_cnt;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
        drain();
        check("fair_max_wait", max_wait <= N_REQ - 1, 1);

        // Operand extremes on channel 0.
        for (int k = 0; k < 4; k++) begin
            set_op(0, int'(ext_a[k]), int'(ext_b[k]));
            req_valid = 4'b0001;
            tick();
            drain();
            check("extreme", res_slice(0), ext_r[k]);
        end

        // Reset with two entries in flight.
        set_op(0, 300, 300);
        set_op(1, -300, 300);
        req_valid = 4'b0011;
        tick();
        tick();
        apply_reset(2);
        req_valid = '0;
        for (int n = 0; n < 6; n++) tick();
        check("post_rst_quiet", res_valid, 0);
        req_valid = 4'b1111;
        #1;
        check("post_rst_first_grant", req_ready, 4'b0001);
        tick();
        drain();

        // Channel 2 alone, back to back with a ramp.
        cap_q.delete();
        req_valid = 4'b0100;
        for (int n = 0; n < 8; n++) begin
            set_op(2, n + 1, 8191);
            tick();
        end
        drain();
        check("ramp_count", cap_q.size(), 8);
        for (int n = 0; n < 8; n++) begin
            if (n < cap_q.size()) check("ramp_value", cap_q[n], ramp_r[n]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
